axicb_round_robin_qos: RTL and testbench
========================================

// Module: axicb_round_robin_qos
// PURPOSE
//  Parametrised round-robin arbiter with priority classes and grant hold. It
//  serves any REQ_NB and keeps one round-robin mask per priority class. A grant
//  is registered and held until the owner signals `done`, e.g. xLAST/xRESP
//  accepted. Sits in switch slave/master arbitration paths in front of a mux.
// PARAMETERS
//  REQ_NB   4  number of requesters, >=2, need not be a power of 2
//  PRIO_NB  4  number of priority classes, >=1; higher value = higher priority
//  PRIO_W   $clog2(PRIO_NB) (1 if PRIO_NB==1), width of one priority field (derived)
//  IDX_W    $clog2(REQ_NB), width of grant_idx (derived)
// PORTS
//  aclk       in   1              clock, rising edge
//  aresetn    in   1              asynchronous active-low reset
//  srst       in   1              synchronous reset, active high
//  en         in   1              allows a new arbitration in IDLE
//  req        in   REQ_NB         request vector
//  prio       in   REQ_NB*PRIO_W  priority of requester i at [i*PRIO_W +: PRIO_W]
//  done       in   1              current owner finished; releases the grant
//  grant      out  REQ_NB         one-hot registered grant
//  grant_idx  out  IDX_W          binary index of the granted requester
//  grant_vld  out  1              high while a grant is held (== |grant)
// BEHAVIOUR
//  Reset (aresetn low, async; or srst high at an edge):
//   - state=IDLE, grant=0, grant_idx=0, grant_vld=0.
//   - All PRIO_NB masks = all ones.
//   - srst dominates done and en.
//  States:
//   - IDLE: if en && |req at edge -> register winner, go BUSY.
//   - BUSY: hold grant/idx; req, prio and en are ignored.
//   - BUSY: done at edge -> grant=0, grant_vld=0, update mask, go IDLE.
//   - done is ignored in IDLE.
//  Winner selection (combinational, evaluated in IDLE only):
//   1) Pc = highest prio value among active requesters; class C = {i: req[i] && prio[i]==Pc}.
//   2) If C & mask[Pc] != 0, pick its lowest index.
//   3) Else pick the lowest index in C (wrap-around).
//   - prio values >= PRIO_NB are saturated to PRIO_NB-1.
//  Mask update, on release only, class Pc of the released grant only:
//   - mask[Pc] = ones above winner index w: bits w+1..REQ_NB-1 set.
//   - If w==REQ_NB-1, mask[Pc] = all ones.
//   - Masks of other classes are untouched. Higher classes therefore never
//     disturb lower-class fairness.
//  Timing:
//   - Grant appears 1 cycle after the req edge that arbitrated.
//   - The minimum grant length is 1 cycle (done may be high in the first BUSY
//     cycle).
//   - Release -> next grant takes 1 IDLE bubble cycle (done edge, then
//     arbitration edge).
//  Requester rules:
//   - Owner must keep req high until done; a dropped req does not release.
//   - A simultaneous req change in the done cycle is ignored until IDLE.
//  Reset mid-BUSY: grant dropped immediately (async) or at edge (srst), with no
//  mask update.
// TESTING
//  T1 REQ_NB=4, all prio 0, req=1111, done one cycle after each grant ->
//     grant 0001,0010,0100,1000,0001; one bubble between each.
//  T2 req=1101, prio 0 -> grant 0001,0100,1000,0001 (index 1 skipped).
//  T3 req=0011 after req1 granted (mask 1100) -> grant 0001 (wrap-around),
//     mask 1110.
//  T4 prio[2]=2, others 0, req=1111 -> grant 0100 repeatedly. Drop req2 ->
//     grant 0001 (prio-0 mask was still all ones).
//  T5 hold: grant 0010, then req1->0, req0->1 without done -> grant stays 0010
//     for 10 cycles until done.
//  T6 REQ_NB=5, PRIO_NB=1, req=11111 -> grant_idx 0,1,2,3,4,0. aresetn pulse in
//     BUSY -> grant 0 at once; next grant idx 0.

Source files
------------

// File: rtl/axicb_round_robin_qos_if.sv
// Arbitration bus between requesters and the round-robin QoS arbiter.
// The requester side drives req/prio/done/en; the arbiter returns the held grant.
interface axicb_round_robin_qos_if #(
    parameter int REQ_NB  = 4,
    parameter int PRIO_NB = 4,
    parameter int PRIO_W  = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1,
    parameter int IDX_W   = $clog2(REQ_NB)
);
    logic                     en;
    logic [REQ_NB-1:0]        req;
    logic [REQ_NB*PRIO_W-1:0] prio;
    logic                     done;
    logic [REQ_NB-1:0]        grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_vld;

    modport master (
        output en, req, prio, done,
        input  grant, grant_idx, grant_vld
    );

    modport slave (
        input  en, req, prio, done,
        output grant, grant_idx, grant_vld
    );
endinterface

// File: rtl/axicb_round_robin_qos.sv
// Round-robin arbiter with per-class masks and a registered grant held until done.
//   state | meaning
//   IDLE  | no owner; arbitrate when en && |req
//   BUSY  | grant held for the owner until done
module axicb_round_robin_qos #(
    parameter int REQ_NB  = 4,
    parameter int PRIO_NB = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    axicb_round_robin_qos_if.slave   bus
);
    localparam int PRIO_W = (PRIO_NB > 1) ? $clog2(PRIO_NB) : 1;
    localparam int IDX_W  = $clog2(REQ_NB);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_d;
    logic                load;
    logic                rel;
    logic [REQ_NB-1:0]   grant_q;
    logic [IDX_W-1:0]    idx_q;
    logic [PRIO_W-1:0]   cls_q;
    logic [REQ_NB-1:0]   mask [PRIO_NB];

    int                  psat [REQ_NB];
    int                  pc;
    logic [REQ_NB-1:0]   cls_vec;
    logic [REQ_NB-1:0]   cls_mask;
    logic [REQ_NB-1:0]   sel_mask;
    logic [REQ_NB-1:0]   mask_upd;
    logic [IDX_W-1:0]    win_idx;

    // Winner: top active class, lowest masked member, else lowest member (wrap)
    always_comb begin
        pc       = 0;
        cls_vec  = '0;
        sel_mask = '1;
        win_idx  = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            psat[i] = int'(bus.prio[i*PRIO_W +: PRIO_W]);
            if (psat[i] > PRIO_NB - 1) psat[i] = PRIO_NB - 1;
        end
        for (int i = 0; i < REQ_NB; i++) begin
            if (bus.req[i] && psat[i] > pc) pc = psat[i];
        end
        for (int i = 0; i < REQ_NB; i++) begin
            cls_vec[i] = bus.req[i] && (psat[i] == pc);
        end
        for (int k = 0; k < PRIO_NB; k++) begin
            if (k == pc) sel_mask = mask[k];
        end
        cls_mask = cls_vec & sel_mask;
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if (cls_vec[i]) win_idx = IDX_W'(i);
        end
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if (cls_mask[i]) win_idx = IDX_W'(i);
        end
    end

    // Released owner goes to the back of its class; last index reopens all
    always_comb begin
        mask_upd = '0;
        for (int j = 0; j < REQ_NB; j++) begin
            mask_upd[j] = (j > int'(idx_q));
        end
        if (int'(idx_q) == REQ_NB - 1) mask_upd = '1;
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        rel     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && |bus.req) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.done) begin
                    rel     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            cls_q   <= '0;
            for (int k = 0; k < PRIO_NB; k++) mask[k] <= '1;
        end else if (srst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            cls_q   <= '0;
            for (int k = 0; k < PRIO_NB; k++) mask[k] <= '1;
        end else begin
            state <= state_d;
            if (load) begin
                grant_q <= REQ_NB'(1) << win_idx;
                idx_q   <= win_idx;
                cls_q   <= PRIO_W'(pc);
            end
            if (rel) begin
                grant_q <= '0;
                for (int k = 0; k < PRIO_NB; k++) begin
                    if (k == int'(cls_q)) mask[k] <= mask_upd;
                end
            end
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.grant_vld = |grant_q;
endmodule

// File: tb/tb_axicb_round_robin_qos.sv
// Bench for the round-robin QoS arbiter: two instances (4 req/4 classes and
// 5 req/1 class) checked against a per-class pointer model through a scoreboard.
module tb_axicb_round_robin_qos;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;
    logic en      = 1'b0;

    logic [4:0] req_v  [2];
    logic [1:0] pr     [2][5];
    logic       done_v [2];

    logic [4:0] gnt  [2];
    logic [2:0] gidx [2];
    logic       gvld [2];

    axicb_round_robin_qos_if #(.REQ_NB(4), .PRIO_NB(4)) bus0 ();
    axicb_round_robin_qos_if #(.REQ_NB(5), .PRIO_NB(1)) bus1 ();

    axicb_round_robin_qos #(.REQ_NB(4), .PRIO_NB(4)) u_dut0 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus0)
    );
    axicb_round_robin_qos #(.REQ_NB(5), .PRIO_NB(1)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(bus1)
    );

    assign bus0.en   = en;
    assign bus0.req  = req_v[0][3:0];
    assign bus0.done = done_v[0];
    assign bus0.prio = {pr[0][3], pr[0][2], pr[0][1], pr[0][0]};
    assign bus1.en   = en;
    assign bus1.req  = req_v[1];
    assign bus1.done = done_v[1];
    assign bus1.prio = {pr[1][4][0], pr[1][3][0], pr[1][2][0], pr[1][1][0], pr[1][0][0]};

    assign gnt[0]  = {1'b0, bus0.grant};
    assign gidx[0] = {1'b0, bus0.grant_idx};
    assign gvld[0] = bus0.grant_vld;
    assign gnt[1]  = bus1.grant;
    assign gidx[1] = bus1.grant_idx;
    assign gvld[1] = bus1.grant_vld;

    always #5 aclk = ~aclk;

    // Reference model: per class, a pointer to where the circular search starts
    int nr [2] = '{4, 5};
    int np [2] = '{4, 1};
    int pw [2] = '{2, 1};
    int ptr  [2][4];
    bit busy [2];
    int held [2];
    int hcls [2];
    int expq [2][$];
    int obs  [2][$];
    bit prev [2];

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input int d, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int prio_of(input int d, input int i);
        int v;
        v = int'(pr[d][i]) & ((1 << pw[d]) - 1);
        return (v > np[d] - 1) ? np[d] - 1 : v;
    endfunction

    function automatic int pick(input int d, output int c);
        int idx;
        c = -1;
        for (int i = 0; i < nr[d]; i++)
            if (req_v[d][i] && prio_of(d, i) > c) c = prio_of(d, i);
        for (int k = 0; k < nr[d]; k++) begin
            idx = (ptr[d][c] + k) % nr[d];
            if (req_v[d][idx] && prio_of(d, idx) == c) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset(input int d);
        busy[d] = 1'b0;
        for (int c = 0; c < 4; c++) ptr[d][c] = 0;
        expq[d].delete();
    endtask

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int d = 0; d < 2; d++) model_reset(d);
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (srst) begin
                    model_reset(d);
                end else if (busy[d]) begin
                    if (done_v[d]) begin
                        busy[d] = 1'b0;
                        ptr[d][hcls[d]] = (held[d] + 1) % nr[d];
                    end
                end else if (en && req_v[d] != 0) begin
                    held[d] = pick(d, hcls[d]);
                    busy[d] = 1'b1;
                    expq[d].push_back(held[d]);
                end
            end
        end
    end

    // Monitor: compares on the falling edge, pops an expectation per new grant
    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            check(gvld[d] == busy[d], "grant_vld", d, int'(gvld[d]), int'(busy[d]));
            if (gvld[d] && !prev[d]) begin
                if (expq[d].size() == 0) begin
                    check(1'b0, "unexpected_grant", d, int'(gnt[d]), 0);
                end else begin
                    int e;
                    e = expq[d].pop_front();
                    check(int'(gnt[d]) == (1 << e), "grant", d, int'(gnt[d]), 1 << e);
                    check(int'(gidx[d]) == e, "grant_idx", d, int'(gidx[d]), e);
                end
                obs[d].push_back(int'(gidx[d]));
            end else if (gvld[d]) begin
                check(int'(gnt[d]) == (1 << held[d]), "grant_hold", d, int'(gnt[d]), 1 << held[d]);
            end else begin
                check(gnt[d] == 5'd0, "grant_idle", d, int'(gnt[d]), 0);
            end
            prev[d] = gvld[d];
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic do_srst();
        req_v[0] = '0; req_v[1] = '0;
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        obs[0].delete(); obs[1].delete();
    endtask

    task automatic expect_seq(input int d, input string name, input int n,
                              input int a0 = 0, input int a1 = 0, input int a2 = 0,
                              input int a3 = 0, input int a4 = 0, input int a5 = 0);
        int w [6];
        w = '{a0, a1, a2, a3, a4, a5};
        check(obs[d].size() >= n, {name, "_count"}, d, obs[d].size(), n);
        for (int i = 0; i < n && i < obs[d].size(); i++)
            check(obs[d][i] == w[i], name, d, obs[d][i], w[i]);
    endtask

    task automatic areset_pulse();
        aresetn = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            check(gvld[d] == 1'b0, "async_vld", d, int'(gvld[d]), 0);
            check(gidx[d] == 3'd0, "async_idx", d, int'(gidx[d]), 0);
        end
        #2;
        aresetn = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_v[d] = '0;
            done_v[d] = 1'b0;
            for (int i = 0; i < 5; i++) pr[d][i] = '0;
        end
        step(2);
        for (int d = 0; d < 2; d++) begin
            check(gvld[d] == 1'b0, "reset_vld", d, int'(gvld[d]), 0);
            check(gnt[d] == 5'd0, "reset_grant", d, int'(gnt[d]), 0);
            check(gidx[d] == 3'd0, "reset_idx", d, int'(gidx[d]), 0);
        end
        aresetn = 1'b1;
        en = 1'b1;
        step(1);

        // Equal priority full rotation
        do_srst();
        done_v[0] = 1'b1;
        req_v[0] = 5'b01111;
        step(10);
        req_v[0] = '0;
        step(2);
        expect_seq(0, "t1_seq", 5, 0, 1, 2, 3, 0);

        // Gap in the request vector
        do_srst();
        req_v[0] = 5'b01101;
        step(8);
        req_v[0] = '0;
        step(2);
        expect_seq(0, "t2_seq", 4, 0, 2, 3, 0);

        // Wrap-around below the mask
        do_srst();
        req_v[0] = 5'b00010;
        step(1);
        req_v[0] = 5'b00011;
        step(6);
        req_v[0] = '0;
        step(2);
        expect_seq(0, "t3_seq", 3, 1, 0, 1);

        // High class dominates, low class mask untouched
        do_srst();
        pr[0][2] = 2'd2;
        req_v[0] = 5'b01111;
        step(6);
        req_v[0] = 5'b01011;
        step(2);
        req_v[0] = '0;
        step(2);
        pr[0][2] = 2'd0;
        expect_seq(0, "t4_seq", 4, 2, 2, 2, 0);

        // Grant held while req changes and done stays low
        do_srst();
        done_v[0] = 1'b0;
        req_v[0] = 5'b00010;
        step(1);
        req_v[0] = 5'b00001;
        step(10);
        check(gnt[0] == 5'b00010, "t5_hold", 0, int'(gnt[0]), 2);
        done_v[0] = 1'b1;
        step(4);
        req_v[0] = '0;
        step(2);
        expect_seq(0, "t5_seq", 2, 1, 0);

        // Five requesters, single class, then async reset mid-grant
        do_srst();
        done_v[1] = 1'b1;
        req_v[1] = 5'b11111;
        step(12);
        expect_seq(1, "t6_seq", 6, 0, 1, 2, 3, 4, 0);
        done_v[1] = 1'b0;
        step(2);
        check(gvld[1] == 1'b1, "t6_busy", 1, int'(gvld[1]), 1);
        areset_pulse();
        obs[1].delete();
        done_v[1] = 1'b1;
        step(4);
        req_v[1] = '0;
        step(2);
        expect_seq(1, "t6_after_reset", 1, 0);

        // Randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            en   = ($urandom_range(0, 9) != 0);
            srst = ($urandom_range(0, 149) == 0);
            req_v[0] = 5'($urandom) & 5'h0F;
            req_v[1] = 5'($urandom);
            for (int d = 0; d < 2; d++) begin
                done_v[d] = ($urandom_range(0, 2) == 0);
                for (int i = 0; i < 5; i++) pr[d][i] = 2'($urandom);
            end
            if (n == 1500) areset_pulse();
            step(1);
        end
        srst = 1'b0;
        req_v[0] = '0; req_v[1] = '0;
        done_v[0] = 1'b1; done_v[1] = 1'b1;
        step(4);
        for (int d = 0; d < 2; d++)
            check(expq[d].size() == 0, "queue_drained", d, expq[d].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
